muldiv_unit: RTL

Iterative multi-cycle multiply/divide unit covering the full RV32M set (mul, mulh, mulhsu, mulhu, div, divu, rem, remu) with RISC-V corner-case semantics.
- Sits beside the single-cycle ALU in the execute stage. The ALU keeps add/logic/shift/Zbb work; this block takes over all M-extension ops so the ALU no longer needs wide combinational multipliers or dividers.
- Uses a valid/ready handshake on both sides. Parametrised in width.
- Supports a flush input so the pipeline can abandon an in-flight op.

---
 rtl/muldiv_pkg.sv | 32 +++
 rtl/muldiv_unit.sv | 138 +++++++++++++
 2 files changed

// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit.
package muldiv_pkg;

    localparam int unsigned DEFAULT_DATA_WIDTH = 32;

    // RV32M operation encoding on op_i
    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_MULHU  = 3'd3;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_DIVU   = 3'd5;
    localparam logic [2:0] OP_REM    = 3'd6;
    localparam logic [2:0] OP_REMU   = 3'd7;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_e;

    // rs1 is treated as signed for mulh, mulhsu, div and rem
    function automatic logic op_a_signed(input logic [2:0] op);
        return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    endfunction

    // rs2 is treated as signed for mulh, div and rem
    function automatic logic op_b_signed(input logic [2:0] op);
        return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and
// restoring divide on magnitudes, sharing one double-width accumulator.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  logic [2:0]            op_i,
    input  logic [DATA_WIDTH-1:0] a_i,
    input  logic [DATA_WIDTH-1:0] b_i,
    input  logic                  kill_i,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic [DATA_WIDTH-1:0] res_o
);

    localparam int unsigned W     = DATA_WIDTH;
    localparam int unsigned CNT_W = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DATA_WIDTH - 1);
    localparam logic [W-1:0]     MIN_VAL   = {1'b1, {(W - 1){1'b0}}};

    state_e           state_q;
    logic [2:0]       op_q;
    logic             sa_q;      // effective sign of rs1
    logic             sb_q;      // effective sign of rs2
    logic [W-1:0]     opnd_q;    // multiplicand (mul) or divisor (div) magnitude
    logic [2*W-1:0]   acc_q;     // mul: {partial, multiplier}; div: {remainder, dividend/quotient}
    logic [CNT_W-1:0] cnt_q;
    logic [W-1:0]     res_q;

    logic             a_neg, b_neg, div_zero, div_ovf;
    logic [W-1:0]     a_mag, b_mag, spec_res;
    logic [W:0]       mul_sum, rem_sh, div_diff;
    logic [2*W-1:0]   acc_step, prod;
    logic [W-1:0]     quot, rmdr, fix_res;

    // Decode the incoming request: magnitudes, signs and the early-out cases
    always_comb begin
        a_neg    = op_a_signed(op_i) && a_i[W-1];
        b_neg    = op_b_signed(op_i) && b_i[W-1];
        a_mag    = a_neg ? -a_i : a_i;
        b_mag    = b_neg ? -b_i : b_i;
        div_zero = op_i[2] && (b_i == '0);
        div_ovf  = ((op_i == OP_DIV) || (op_i == OP_REM)) && (a_i == MIN_VAL) && (b_i == '1);
        spec_res = '0;
        if (div_zero) begin
            spec_res = ((op_i == OP_DIV) || (op_i == OP_DIVU)) ? '1 : a_i;
        end else if (div_ovf) begin
            spec_res = (op_i == OP_DIV) ? MIN_VAL : '0;
        end
    end

    // One iteration of the shared datapath plus the sign fixup of its outcome
    always_comb begin
        mul_sum  = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        rem_sh   = acc_q[2*W-1:W-1];
        div_diff = rem_sh - {1'b0, opnd_q};
        if (op_q[2]) begin
            // Keep the trial subtraction only if it did not borrow
            if (!div_diff[W]) begin
                acc_step = {div_diff[W-1:0], acc_q[W-2:0], 1'b1};
            end else begin
                acc_step = {rem_sh[W-1:0], acc_q[W-2:0], 1'b0};
            end
        end else begin
            acc_step = {mul_sum, acc_q[W-1:1]};
        end
        prod = (sa_q ^ sb_q) ? -acc_step : acc_step;
        quot = (sa_q ^ sb_q) ? -acc_step[W-1:0] : acc_step[W-1:0];
        rmdr = sa_q ? -acc_step[2*W-1:W] : acc_step[2*W-1:W];
        case (op_q)
            OP_MUL:                       fix_res = prod[W-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: fix_res = prod[2*W-1:W];
            OP_DIV, OP_DIVU:              fix_res = quot;
            default:                      fix_res = rmdr;
        endcase
    end

    // Control FSM and datapath registers; kill outranks every transition
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            op_q    <= OP_MUL;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            opnd_q  <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            res_q   <= '0;
        end else if (kill_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (valid_i) begin
                        if (div_zero || div_ovf) begin
                            res_q   <= spec_res;
                            state_q <= DONE;
                        end else begin
                            op_q    <= op_i;
                            sa_q    <= a_neg;
                            sb_q    <= b_neg;
                            opnd_q  <= op_i[2] ? b_mag : a_mag;
                            acc_q   <= {{W{1'b0}}, (op_i[2] ? a_mag : b_mag)};
                            cnt_q   <= '0;
                            state_q <= CALC;
                        end
                    end
                end
                CALC: begin
                    acc_q <= acc_step;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == LAST_STEP) begin
                        res_q   <= fix_res;
                        cnt_q   <= '0;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    if (ready_i) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ready_o = rst_ni && (state_q == IDLE);
    assign valid_o = (state_q == DONE);
    assign res_o   = res_q;

endmodule
